// File: rtl/mem_stage.sv
// MEM stage: data-memory access with a MEM_LATENCY wait-state FSM, beq resolution and MEM/WB register.
// Optional macro MEM_MISALIGN_CHECK_EN adds a sticky misaligned-access flag and suppresses the offending access.
module mem_stage #(
    parameter int ADDR_WIDTH  = 10,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        beq_instruction_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] mux2_result_in,
    input  logic [4:0]  reg_rd_in,
    input  logic        flag_beq_in,
    output logic        pc_src,
    output logic        mem_stall,
    output logic [31:0] alu_ex_mem,
    output logic [4:0]  ex_mem_reg_rd,
    output logic        ex_mem_reg_write,
    output logic        mem_to_reg_out,
    output logic        reg_write_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  reg_rd_out,
    output logic [31:0] alu_data_mem_wb,
    output logic        mem_misaligned
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] LAT_M1 = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  access, complete, mis_acc;
    state_t                state, state_nx;
    logic [3:0]            cnt, cnt_nx;
    logic                  unused_addr_bits;

    assign idx              = alu_result_in[ADDR_WIDTH+1:2];
    assign access           = mem_read_in | mem_write_in;
    assign unused_addr_bits = ^{alu_result_in[31:ADDR_WIDTH+2], alu_result_in[1:0]};

    assign pc_src           = beq_instruction_in & flag_beq_in;
    assign alu_ex_mem       = alu_result_in;
    assign ex_mem_reg_rd    = reg_rd_in;
    assign ex_mem_reg_write = reg_write_in;
    assign alu_data_mem_wb  = mem_to_reg_out ? read_data_out : alu_result_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (access && MEM_LATENCY > 0) begin
                state_nx = WAIT;
                cnt_nx   = LAT_M1;
            end
            WAIT: if (cnt == 4'd0) state_nx = IDLE;
                  else             cnt_nx   = cnt - 4'd1;
            default: state_nx = IDLE;
        endcase
    end

    // Reset masks completion so a store caught mid-wait is never written.
    always_comb begin
        mem_stall = 1'b0;
        complete  = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: if (access && MEM_LATENCY > 0) mem_stall = 1'b1;
                      else                           complete  = 1'b1;
                WAIT: if (cnt != 4'd0) mem_stall = 1'b1;
                      else             complete  = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis_acc = access & (alu_result_in[1:0] != 2'b00);

    always_ff @(posedge clock) begin
        if (reset)                    mem_misaligned <= 1'b0;
        else if (complete && mis_acc) mem_misaligned <= 1'b1;
    end
`else
    assign mis_acc        = 1'b0;
    assign mem_misaligned = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (complete && mem_write_in && !mis_acc) mem[idx] <= mux2_result_in;
    end

    // Non-completing cycles push a bubble; read data is the pre-write word.
    always_ff @(posedge clock) begin
        if (reset || !complete) begin
            mem_to_reg_out <= 1'b0;
            reg_write_out  <= 1'b0;
            read_data_out  <= 32'd0;
            alu_result_out <= 32'd0;
            reg_rd_out     <= 5'd0;
        end else begin
            mem_to_reg_out <= mem_to_reg_in;
            reg_write_out  <= reg_write_in;
            read_data_out  <= mis_acc ? 32'd0 : mem[idx];
            alu_result_out <= alu_result_in;
            reg_rd_out     <= reg_rd_in;
        end
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline, downstream of the EX/MEM register.
- Consumes the EX/MEM outputs and performs data-memory access with a configurable wait-state FSM.
- Resolves beq by asserting pc_src, and holds the MEM/WB pipeline register.
- Returns forwarding data (alu_ex_mem, alu_data_mem_wb, rd and reg_write of both stages) to the EX forwarding unit.

Parameters:
- ADDR_WIDTH, 10, word-address bits of the data memory (2^ADDR_WIDTH 32-bit words).
- MEM_LATENCY, 2, wait cycles per load/store (0..15); 0 means single-cycle access.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_to_reg_in  in  1  WB select from EX/MEM.
- reg_write_in  in  1  WB write enable from EX/MEM.
- mem_read_in  in  1  load request.
- mem_write_in  in  1  store request.
- beq_instruction_in  in  1  instruction is beq.
- alu_result_in  in  32  ALU result / byte address.
- mux2_result_in  in  32  store data.
- reg_rd_in  in  5  destination register.
- flag_beq_in  in  1  ALU equality flag.
- pc_src  out  1  branch taken.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- alu_ex_mem  out  32  forward value from the EX/MEM stage.
- ex_mem_reg_rd  out  5  forward rd from the EX/MEM stage.
- ex_mem_reg_write  out  1  forward write enable from the EX/MEM stage.
- mem_to_reg_out  out  1  MEM/WB register output.
- reg_write_out  out  1  MEM/WB register output; also mem_wb_reg_write for forwarding.
- read_data_out  out  32  MEM/WB register output.
- alu_result_out  out  32  MEM/WB register output.
- reg_rd_out  out  5  MEM/WB register output; also mem_wb_reg_rd for forwarding.
- alu_data_mem_wb  out  32  WB mux result, forwarded to EX.
- mem_misaligned  out  1  sticky misalignment flag (only with MEM_MISALIGN_CHECK_EN).

Behaviour:
- Combinational outputs:
  - pc_src = beq_instruction_in & flag_beq_in.
  - alu_ex_mem = alu_result_in.
  - ex_mem_reg_rd = reg_rd_in.
  - ex_mem_reg_write = reg_write_in.
  - alu_data_mem_wb = mem_to_reg_out ? read_data_out : alu_result_out.
- Word index is alu_result_in[ADDR_WIDTH+1:2]; upper address bits are ignored and the address wraps modulo the memory size. Memory contents are not cleared by reset.
- access = mem_read_in | mem_write_in.
- FSM states: IDLE, WAIT. Wait counter cnt is 4 bits.
  - IDLE, no access: complete; mem_stall=0.
  - IDLE, access, MEM_LATENCY=0: complete this cycle; mem_stall=0.
  - IDLE, access, MEM_LATENCY>0: mem_stall=1; next state WAIT with cnt=MEM_LATENCY-1.
  - WAIT, cnt!=0: mem_stall=1; cnt decrements.
  - WAIT, cnt==0: complete; mem_stall=0; next state IDLE.
  - Result: exactly MEM_LATENCY stall cycles per access.
- Upstream holds all inputs stable while mem_stall=1.
- Completion cycle, at the clock edge:
  - If mem_write_in, mem[idx] <= mux2_result_in. The store is performed exactly once.
  - The MEM/WB register loads all inputs.
  - read_data_out loads mem[idx], using the pre-write value when a store is in the same cycle.
- Stall cycles: the MEM/WB register loads a bubble (mem_to_reg_out=0, reg_write_out=0, reg_rd_out=0, data 0). No memory write occurs.
- Simultaneous mem_read_in and mem_write_in: treated as a store; read_data_out captures the old word.
- Back-to-back accesses: the next access starts its own full wait sequence in the cycle after completion.
- Reset (synchronous):
  - State=IDLE, cnt=0, mem_stall=0 during the reset cycle.
  - All MEM/WB outputs=0; mem_misaligned=0.
  - A pending store is aborted and never written.
  - The first access after reset deassertion starts a fresh wait sequence.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - An access with alu_result_in[1:0]!=0 sets mem_misaligned in its completion cycle; the flag is sticky until reset.
  - The offending store is suppressed.
  - The offending load writes read_data_out=0.
  - The wait timing is unchanged.
- Undefined: mem_misaligned is tied to 0; the low address bits are ignored.

Test Plan:
- Reset, then no access: MEM/WB outputs all 0, mem_stall=0; ALU op with rd=5, alu_result_in=0x2A, reg_write_in=1 -> next cycle reg_rd_out=5, alu_data_mem_wb=0x2A.
- Store 0xDEADBEEF at 0x10 (MEM_LATENCY=2) -> mem_stall high exactly 2 cycles; 2 bubbles on MEM/WB; mem[4]=0xDEADBEEF after the 3rd edge.
- Load 0x10 to rd=7 with mem_to_reg_in=1 -> read_data_out=0xDEADBEEF after 3 cycles; alu_data_mem_wb=0xDEADBEEF; reg_write_out pulses once.
- beq_instruction_in=1, flag_beq_in=1 -> pc_src=1 in the same cycle, mem_stall=0; flag_beq_in=0 -> pc_src=0.
- Store to 0x20 with reset asserted during the first WAIT cycle -> mem[8] unchanged; mem_stall=0 during the reset cycle; all outputs 0.
- With MEM_MISALIGN_CHECK_EN, store to 0x13 -> mem[4] unchanged; mem_misaligned=1 and held through subsequent aligned accesses until reset.
